fir_mac_sequencer: RTL and testbench

//  Time-multiplexed controller for the FIR datapath. It accepts one sample per handshake,

---
 rtl/fir_mac_sequencer.sv | 130 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample per handshake, a single multiply-accumulate stepped
// over every tap, saturated registered output with a one-cycle valid pulse.
module fir_mac_sequencer #(
    parameter int SIZE      = 8,
    parameter int NUM_COEFF = 4,
    parameter int SHIFT     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SIZE-1:0]              sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         flush,
    input  logic                         coeff_we,
    input  logic [$clog2(NUM_COEFF)-1:0] coeff_sel,
    input  logic [SIZE-1:0]              coeff_data,
    output logic [SIZE-1:0]              y_n,
    output logic                         y_valid,
    output logic                         busy
);

    localparam int TW    = $clog2(NUM_COEFF);
    localparam int PW    = 2 * SIZE;
    localparam int ACC_W = PW + TW;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t            state, state_nxt;
    logic [SIZE-1:0]   x_dl     [NUM_COEFF];
    logic [SIZE-1:0]   c_shadow [NUM_COEFF];
    logic [SIZE-1:0]   c_act    [NUM_COEFF];
    logic [TW-1:0]     tap;
    logic [ACC_W-1:0]  acc;
    logic [PW-1:0]     prod;
    logic              accept;
    logic              last_tap;
    logic              sel_ok;

    function automatic logic [SIZE-1:0] sat(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> SHIFT;
        if (|s[ACC_W-1:SIZE])
            return {SIZE{1'b1}};
        return s[SIZE-1:0];
    endfunction

    assign accept       = (state == IDLE) && sample_valid && !flush;
    assign last_tap     = (tap == TW'(NUM_COEFF - 1));
    assign prod         = PW'(c_act[tap]) * PW'(x_dl[tap]);
    assign sel_ok       = ({{(32-TW){1'b0}}, coeff_sel} < 32'(NUM_COEFF));
    assign sample_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample_valid) state_nxt = MAC;
                MAC:     if (last_tap)     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shadow bank is written in any state; flush never touches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_COEFF; k++)
                c_shadow[k] <= '0;
        end else if (coeff_we && sel_ok) begin
            c_shadow[coeff_sel] <= coeff_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
                x_dl[k]  <= '0;
                c_act[k] <= '0;
            end
            acc     <= '0;
            tap     <= '0;
            y_n     <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (flush) begin
                for (int k = 0; k < NUM_COEFF; k++)
                    x_dl[k] <= '0;
                acc <= '0;
                tap <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            for (int k = NUM_COEFF - 1; k > 0; k--)
                                x_dl[k] <= x_dl[k-1];
                            x_dl[0] <= sample_in;
                            // Snapshot keeps the in-flight result immune to shadow writes.
                            for (int k = 0; k < NUM_COEFF; k++)
                                c_act[k] <= c_shadow[k];
                            acc <= '0;
                            tap <= '0;
                        end
                    end
                    MAC: begin
                        acc <= acc + ACC_W'(prod);
                        tap <= last_tap ? '0 : tap + 1'b1;
                    end
                    DONE: begin
                        y_n     <= sat(acc);
                        y_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (SIZE=8, NUM_COEFF=4, SHIFT=0).
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       flush;
    logic       coeff_we;
    logic [1:0] coeff_sel;
    logic [7:0] coeff_data;
    logic [7:0] y_n;
    logic       y_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    fir_mac_sequencer #(.SIZE(8), .NUM_COEFF(4), .SHIFT(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .flush        (flush),
        .coeff_we     (coeff_we),
        .coeff_sel    (coeff_sel),
        .coeff_data   (coeff_data),
        .y_n          (y_n),
        .y_valid      (y_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coeff(input int sel, input int d);
        coeff_we   = 1'b1;
        coeff_sel  = sel[1:0];
        coeff_data = d[7:0];
        tick();
        coeff_we   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Counts cycles from the accept edge until y_valid, bounded.
    task automatic wait_y(input string tag, input int start, input int exp_lat, input int exp_y);
        int n;
        bit got;
        n   = start;
        got = 1'b0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (y_valid) got = 1'b1;
        end
        check_eq({tag, "_lat"}, got ? n : -1, exp_lat);
        check_eq({tag, "_y"}, 32'(y_n), exp_y);
    endtask

    task automatic feed(input string tag, input int x, input int exp_y);
        int w;
        w = 0;
        while (!sample_ready && w < 20) begin
            tick();
            w++;
        end
        check_eq({tag, "_ready"}, 32'(sample_ready), 1);
        sample_in    = x[7:0];
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_y(tag, 0, 5, exp_y);
    endtask

    initial begin
        int acc_n, pulses, rb_bad;
        rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; flush = 1'b0;
        coeff_we = 1'b0; coeff_sel = '0; coeff_data = '0;
        repeat (3) tick();
        check_eq("rst_y_n", 32'(y_n), 0);
        check_eq("rst_y_valid", 32'(y_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ready", 32'(sample_ready), 1);
        rst_n = 1'b1;
        tick();

        // Impulse response
        write_coeff(0, 1); write_coeff(1, 2); write_coeff(2, 3); write_coeff(3, 4);
        feed("imp0", 1, 1);
        feed("imp1", 0, 2);
        feed("imp2", 0, 3);
        feed("imp3", 0, 4);
        feed("imp4", 0, 0);

        // Saturation
        for (int k = 0; k < 4; k++) write_coeff(k, 255);
        for (int k = 0; k < 4; k++) feed($sformatf("sat%0d", k), 255, 255);

        // Coefficient write during MAC must not affect the in-flight result
        do_flush();
        for (int k = 0; k < 4; k++) write_coeff(k, 1);
        sample_in = 8'd10; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        write_coeff(0, 100);
        wait_y("snap", 1, 5, 10);
        feed("snap_next", 0, 10);

        // sample_valid held high for 20 cycles
        do_flush();
        acc_n = 0; pulses = 0; rb_bad = 0;
        sample_in = 8'd0; sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sample_ready) acc_n++;
            if (sample_ready === busy) rb_bad++;
            if (y_valid) pulses++;
            tick();
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (y_valid) pulses++;
            tick();
        end
        check_eq("hold_accepts", acc_n, 4);
        check_eq("hold_pulses", pulses, 4);
        check_eq("hold_ready_busy", rb_bad, 0);

        // Flush in the 2nd MAC cycle
        write_coeff(0, 7);
        feed("pre_flush", 5, 35);
        sample_in = 8'd9; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        do_flush();
        check_eq("flush_busy", 32'(busy), 0);
        check_eq("flush_ready", 32'(sample_ready), 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (y_valid) pulses++;
            tick();
        end
        check_eq("flush_no_valid", pulses, 0);
        check_eq("flush_keeps_y", 32'(y_n), 35);
        sample_in = 8'd200; sample_valid = 1'b1; flush = 1'b1;
        tick();
        sample_valid = 1'b0; flush = 1'b0;
        check_eq("flush_blocks_accept", 32'(busy), 0);
        feed("post_flush", 1, 7);

        // Asynchronous reset mid-MAC
        sample_in = 8'd3; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check_eq("arst_y_n", 32'(y_n), 0);
        check_eq("arst_y_valid", 32'(y_valid), 0);
        check_eq("arst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        feed("arst_coef", 50, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
